// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared types and sizing helpers for the line buffer read side
package line_buf_pkg;

  localparam int DEF_PX_WIDTH      = 12;
  localparam int DEF_PX_PER_CLK    = 4;
  localparam int DEF_LINES         = 3;
  localparam int DEF_MAX_LINE_SIZE = 1936;

  typedef logic [DEF_PX_PER_CLK*DEF_PX_WIDTH-1:0] px_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } rd_state_t;

  // Wide enough to hold the beat count of a maximum-length line.
  function automatic int beat_cnt_w(input int max_line_size, input int px_per_clk);
    return $clog2(max_line_size / px_per_clk + 1);
  endfunction

endpackage

// File: rtl/line_buf_reader.sv
// rtl/line_buf_reader.sv - pops all line buffers together and emits one aligned column stream
module line_buf_reader
  import line_buf_pkg::*;
#(
  parameter int PX_WIDTH      = DEF_PX_WIDTH,
  parameter int PX_PER_CLK    = DEF_PX_PER_CLK,
  parameter int LINES         = DEF_LINES,
  parameter int MAX_LINE_SIZE = DEF_MAX_LINE_SIZE
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [LINES-1:0]                    empty_i,
  input  logic [LINES-1:0]                    unread_i,
  output logic [LINES-1:0]                    pop_line_o,
  input  logic [LINES*PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
  input  logic [LINES*PX_PER_CLK-1:0]         px_data_val_i,
  input  logic [LINES-1:0]                    line_end_i,
  input  logic [LINES-1:0]                    frame_start_i,
  input  logic [LINES-1:0]                    frame_end_i,
  output logic [LINES*PX_PER_CLK*PX_WIDTH-1:0] win_data_o,
  output logic [PX_PER_CLK-1:0]               win_val_o,
  output logic                                win_line_start_o,
  output logic                                win_line_end_o,
  output logic                                win_frame_start_o,
  output logic                                win_frame_end_o,
  output logic                                busy_o,
  output logic                                align_err_o,
  input  logic                                err_clr_i
);

  localparam int CNT_W = beat_cnt_w(MAX_LINE_SIZE, PX_PER_CLK);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LINE_SIZE / PX_PER_CLK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LINE_SIZE / PX_PER_CLK - 1);

  rd_state_t               state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    first_beat;
  logic                    sof_seen;
  logic                    mismatch;
  logic                    beat;
  logic                    sat_end;
  logic [PX_PER_CLK-1:0]   val0;
  logic                    unused_ok;

  // Frame start is taken from the reference buffer, frame end from the oldest line.
  assign unused_ok = ^{frame_start_i[LINES-1:1], frame_end_i[LINES-2:0]};

  assign val0       = px_data_val_i[PX_PER_CLK-1:0];
  assign beat       = (state == READ) && (|val0);
  assign sat_end    = beat && !line_end_i[0] && (beat_cnt == CNT_LAST);
  assign pop_line_o = {LINES{state == POP}};
  assign busy_o     = (state != IDLE);

  always_comb begin
    mismatch = 1'b0;
    for (int k = 1; k < LINES; k++) begin
      if ((px_data_val_i[k*PX_PER_CLK +: PX_PER_CLK] != val0) ||
          (line_end_i[k] != line_end_i[0]))
        mismatch = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_i && (&unread_i) && !(|empty_i)) state_nxt = POP;
      POP:     state_nxt = READ;
      READ:    if (beat && (line_end_i[0] || sat_end)) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt   <= '0;
      first_beat <= 1'b0;
      sof_seen   <= 1'b0;
    end else if (state == POP) begin
      beat_cnt   <= '0;
      first_beat <= 1'b1;
      sof_seen   <= frame_start_i[0];
    end else if (state == READ) begin
      if (first_beat && frame_start_i[0]) sof_seen <= 1'b1;
      if (beat) begin
        first_beat <= 1'b0;
        if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Single output stage; anything but a valid READ beat clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_data_o        <= '0;
      win_val_o         <= '0;
      win_line_start_o  <= 1'b0;
      win_line_end_o    <= 1'b0;
      win_frame_start_o <= 1'b0;
      win_frame_end_o   <= 1'b0;
    end else if (beat) begin
      win_data_o        <= px_data_i;
      win_val_o         <= val0;
      win_line_start_o  <= first_beat;
      win_line_end_o    <= line_end_i[0] || sat_end;
      win_frame_start_o <= first_beat && (sof_seen || frame_start_i[0]);
      win_frame_end_o   <= line_end_i[0] && frame_end_i[LINES-1];
    end else begin
      win_data_o        <= '0;
      win_val_o         <= '0;
      win_line_start_o  <= 1'b0;
      win_line_end_o    <= 1'b0;
      win_frame_start_o <= 1'b0;
      win_frame_end_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           align_err_o <= 1'b0;
    else if (beat && (mismatch || sat_end)) align_err_o <= 1'b1;
    else if (err_clr_i)                  align_err_o <= 1'b0;
  end

endmodule

// File: tb/tb_line_buf_reader.sv
// tb/tb_line_buf_reader.sv - randomized line-level stimulus against an expected-beat scoreboard
module tb_line_buf_reader;
  import line_buf_pkg::*;

  typedef struct packed {
    logic [143:0] data;
    logic [3:0]   val;
    logic         ls, le, fs, fe;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         err_clr = 1'b0;
  logic [2:0]   empty = '0, unread = '0, line_end = '0, frame_start = '0, frame_end = '0;
  logic [143:0] px_data = '0;
  logic [11:0]  val = '0;
  logic [2:0]   pop;
  logic [143:0] win_data;
  logic [3:0]   win_val;
  logic         win_ls, win_le, win_fs, win_fe, busy, align_err;

  int   total = 0, bad = 0;
  int   pops_exp = 0, pops_seen = 0;
  bit   err_exp = 1'b0;
  exp_t exp_q[$];

  line_buf_reader dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .empty_i(empty), .unread_i(unread),
    .pop_line_o(pop), .px_data_i(px_data), .px_data_val_i(val), .line_end_i(line_end),
    .frame_start_i(frame_start), .frame_end_i(frame_end), .win_data_o(win_data),
    .win_val_o(win_val), .win_line_start_o(win_ls), .win_line_end_o(win_le),
    .win_frame_start_o(win_fs), .win_frame_end_o(win_fe), .busy_o(busy),
    .align_err_o(align_err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pop == 3'b111) pops_seen++;
      else if (pop != 3'b000) chk("pop_partial", 256'(pop), 256'(0));
      if (win_val != 0 || win_ls || win_le || win_fs || win_fe || win_data != 0) begin
        if (exp_q.size() == 0)
          chk("spurious", 256'({win_data, win_val, win_ls, win_le, win_fs, win_fe}), 256'(0));
        else
          chk("beat", 256'({win_data, win_val, win_ls, win_le, win_fs, win_fe}),
              256'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle_window(input logic [2:0] u, input logic [2:0] em, input logic en,
                             input int n, input string tag);
    int cnt;
    cnt = 0;
    unread = u; empty = em; enable = en;
    repeat (n) begin
      step();
      if (pop != 3'b000) cnt++;
    end
    chk(tag, 256'(cnt), 256'(0));
    unread = '0; empty = '0; enable = 1'b1;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    err_exp = 1'b0;
    chk("err_clr", 256'(align_err), 256'(0));
  endtask

  // fe_sel: 0 none, 1 frame end on oldest buffer, 2 frame end on reference buffer only.
  // err_mode: 0 clean, 1 buffer 1 ends one beat early, 2 buffer 2 mask differs on one beat.
  task automatic send_line(input int npix, input bit fs, input int fe_sel, input int err_mode,
                           input bit no_end, input int abort_at);
    int       nb, lastn, waited, eb;
    logic [3:0] m;
    bit       le0;
    px_word_t w0, w1, w2;
    exp_t     e;
    nb = (npix + 3) / 4;
    lastn = npix % 4;
    enable = 1'b1; unread = 3'b111; empty = 3'b000;
    waited = 0;
    do begin
      step();
      waited++;
    end while (pop !== 3'b111 && waited < 20);
    chk("pop_lat", 256'(waited), 256'(1));
    if (pop !== 3'b111) return;
    pops_exp++;
    frame_start = fs ? 3'b111 : 3'b000;
    unread = 3'b000;
    enable = 1'($urandom_range(0, 1));
    step();
    chk("pop_once", 256'(pop), 256'(0));
    frame_start = 3'b000;
    eb = (err_mode == 2) ? int'($urandom_range(0, nb - 1)) : -1;
    for (int b = 0; b < nb; b++) begin
      if (abort_at > 0 && b == abort_at) begin
        chk("pre_rst_val", 256'(win_val != 0), 256'(1));
        #2 rst = 1'b1;
        #1 chk("rst_out", 256'({win_data, win_val, win_ls, win_le, win_fs, win_fe, busy, pop, align_err}),
               256'(0));
        exp_q.delete();
        err_exp = 1'b0;
        val = '0; line_end = '0; frame_end = '0;
        step();
        rst = 1'b0;
        enable = 1'b1;
        step();
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        val = '0; line_end = '0;
        px_data = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        step();
      end
      m = (b == nb - 1 && lastn != 0) ? 4'((1 << lastn) - 1) : 4'hF;
      w0 = {$urandom, 16'($urandom)};
      w1 = {$urandom, 16'($urandom)};
      w2 = {$urandom, 16'($urandom)};
      px_data = {w2, w1, w0};
      val = {m, m, m};
      if (b == eb) val[11:8] = m ^ 4'b0001;
      le0 = (b == nb - 1) && !no_end;
      line_end = {le0, le0, le0};
      if (err_mode == 1) line_end[1] = (b == nb - 2);
      frame_end = 3'b000;
      if (le0 && fe_sel == 1) frame_end[2] = 1'b1;
      if (le0 && fe_sel == 2) frame_end[0] = 1'b1;
      e.data = {w2, w1, w0};
      e.val  = m;
      e.ls   = (b == 0);
      e.le   = (b == nb - 1);
      e.fs   = (b == 0) && fs;
      e.fe   = le0 && (fe_sel == 1);
      exp_q.push_back(e);
      step();
    end
    val = '0; line_end = '0; frame_end = '0;
    chk("busy_drain", 256'(busy), 256'(1));
    step();
    chk("busy_idle", 256'(busy), 256'(0));
    if (err_mode != 0 || no_end) err_exp = 1'b1;
    chk("align_err", 256'(align_err), 256'(err_exp));
    enable = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n, em;
    repeat (3) step();
    chk("rst_state", 256'({win_data, win_val, win_ls, win_le, win_fs, win_fe, busy, pop, align_err}),
        256'(0));
    rst = 1'b0;
    enable = 1'b1;
    step();

    send_line(8, 1'b0, 0, 0, 1'b0, 0);
    send_line(10, 1'b0, 0, 0, 1'b0, 0);
    idle_window(3'b011, 3'b000, 1'b1, 50, "no_pop_two_unread");
    send_line(12, 1'b0, 0, 0, 1'b0, 0);
    idle_window(3'b111, 3'b010, 1'b1, 20, "no_pop_empty");
    idle_window(3'b111, 3'b000, 1'b0, 20, "no_pop_disabled");
    send_line(16, 1'b1, 1, 0, 1'b0, 0);
    send_line(16, 1'b0, 2, 0, 1'b0, 0);

    send_line(12, 1'b0, 0, 1, 1'b0, 0);
    send_line(8, 1'b0, 0, 0, 1'b0, 0);
    clr_err();
    send_line(20, 1'b1, 1, 2, 1'b0, 0);
    clr_err();

    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(5, 40));
      em = int'($urandom_range(0, 2));
      send_line(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), em, 1'b0, 0);
      if (em != 0) clr_err();
    end

    send_line(40, 1'b1, 1, 0, 1'b0, 3);
    send_line(13, 1'b1, 1, 0, 1'b0, 0);

    send_line(1936, 1'b0, 0, 0, 1'b1, 0);
    clr_err();

    repeat (3) step();
    chk("exp_q_empty", 256'(exp_q.size()), 256'(0));
    chk("pop_count", 256'(pops_seen), 256'(pops_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buf_reader.md
Name: line_buf_reader

Overview:
- Read-side controller for a bank of LINES line buffers.
- Watches each buffer's empty/unread status and issues one simultaneous pop_line to all buffers once every buffer holds a complete unread line.
- Registers the returned parallel line streams into one aligned window-column stream with line/frame markers, for the downstream window generator.
- Detects lines whose lengths or valid masks disagree between buffers.

Parameters:
- PX_WIDTH, 12, bits per pixel.
- PX_PER_CLK, 4, pixels per beat.
- LINES, 3, number of line buffers read in parallel (≥2).
- MAX_LINE_SIZE, 1936, maximum pixels per line; sizes the beat counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  allow new pops; a read in progress always completes.
- empty_i  in  LINES  per-buffer empty flag.
- unread_i  in  LINES  per-buffer "complete line not yet popped".
- pop_line_o  out  LINES  pop strobe to each buffer.
- px_data_i  in  LINES×PX_PER_CLK×PX_WIDTH  per-buffer read data.
- px_data_val_i  in  LINES×PX_PER_CLK  per-buffer pixel valid mask.
- line_end_i  in  LINES  per-buffer line end.
- frame_start_i  in  LINES  per-buffer frame start.
- frame_end_i  in  LINES  per-buffer frame end.
- win_data_o  out  LINES×PX_PER_CLK×PX_WIDTH  aligned column data.
- win_val_o  out  PX_PER_CLK  column pixel valid.
- win_line_start_o  out  1  first valid beat of column line.
- win_line_end_o  out  1  last valid beat.
- win_frame_start_o  out  1  first beat of first line of frame.
- win_frame_end_o  out  1  last beat of last line of frame.
- busy_o  out  1  read in progress.
- align_err_o  out  1  sticky misalignment flag.
- err_clr_i  in  1  clears align_err_o.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0, sticky flags 0.
- Index 0 is the reference buffer; index LINES-1 is the oldest line.
- FSM states: IDLE, POP, READ, DRAIN.
  - IDLE → POP when enable_i && &unread_i && ~|empty_i.
  - POP: pop_line_o = all ones for exactly one cycle; clear sof_seen, beat_cnt, first_beat ← 1; go to READ.
  - READ: on each cycle with |px_data_val_i[0], register a beat. When line_end_i[0] is registered, go to DRAIN.
  - DRAIN: one cycle for the output register; then IDLE.
  - Minimum gap between successive pops: 1 cycle in IDLE.
- pop_line_o is never asserted outside POP.
- enable_i low in READ or DRAIN has no effect on the current line.
- frame_start_i[0] seen any time from POP to the first valid beat sets sof_seen. Buffers flag frame start at pop time, before data.
- Output pipeline: one register stage. Outputs at cycle t+1 reflect inputs at cycle t during READ.
  - win_data_o = px_data_i; win_val_o = px_data_val_i[0].
  - win_line_start_o = 1 on the first beat with |px_data_val_i[0] after POP.
  - win_frame_start_o = win_line_start_o && sof_seen.
  - win_line_end_o = registered line_end_i[0].
  - win_frame_end_o = registered line_end_i[0] && frame_end_i[LINES-1]. Frame ends only when the oldest line closes the frame.
  - win_val_o = 0 outside READ.
- Beat counter: width $clog2(MAX_LINE_SIZE/PX_PER_CLK+1). It increments per valid beat, saturates at max, and resets in POP.
- align_err_o is set when, on any valid beat, either:
  - px_data_val_i[k] ≠ px_data_val_i[0] for some k, or
  - line_end_i[k] ≠ line_end_i[0] for some k.
- align_err_o also sets if the beat counter saturates without a line end; in that case force READ → DRAIN with win_line_end_o = 1.
- align_err_o clears only on err_clr_i. If set and clear occur in the same cycle, set wins.
- busy_o = 1 in POP, READ, DRAIN.
- Reset mid-READ: outputs drop to 0 asynchronously and the FSM returns to IDLE. The partially read line is abandoned; a fresh pop is required.
- Simultaneous unread rising on the last buffer and enable_i rising: pop occurs the next cycle (IDLE evaluates registered status only).

Decomposition:
- Package line_buf_pkg:
  - px_word_t (PX_PER_CLK×PX_WIDTH packed)
  - rd_state_t enum {IDLE, POP, READ, DRAIN}
  - BEAT_CNT_W function of MAX_LINE_SIZE and PX_PER_CLK
- No sub-module needed. A line_buf_reader_chk sub-module for alignment compare is optional; keep it in-file.

Test Plan:
- 3 buffers, 8-px line (2 beats), all unread: exactly one pop cycle.
  - win_val_o = 4'hF for 2 beats.
  - line_start on beat 1, line_end on beat 2.
  - busy_o falls 1 cycle after line_end.
- 10-px line, last beat mask 4'b0011: win_val_o = F, F, 3; line_end_o with 3.
- Only 2 of 3 buffers unread: no pop for 50 cycles. Third becomes unread: pop next cycle.
- frame_start_i[0] at pop and frame_end_i[2] at line end:
  - win_frame_start_o on the first beat.
  - win_frame_end_o on the last beat.
  - With frame_end_i only on buffer 0: no frame_end.
- Buffer 1 line_end one beat early: align_err_o = 1 and stays set; err_clr_i pulse clears it.
- rst_i mid-READ: all outputs 0 immediately. After release with all unread, a new pop occurs and a full line is output.
